// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory-model view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata,
               mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata,
               mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) single-port memory arbiter; LS priority with fetch starvation guard.
// Grant is combinational in IDLE; mem_req the cycle after; rvalid one cycle after mem_ready.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [2:0]  starve_q, starve_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        ls_rvalid_q, ls_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        if_gnt, ls_gnt;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Fetch wins only when alone or when LS has hogged STARVE_MAX grants in a row.
                if (!rst && bus.if_req && (!bus.ls_req || starve_q == STARVE_LIM)) begin
                    if_gnt   = 1'b1;
                    state_d  = BUSY_IF;
                    starve_d = 3'd0;
                    we_d     = 1'b0;
                    be_d     = 4'hF;
                    addr_d   = bus.if_addr;
                    wdata_d  = 32'd0;
                end else if (!rst && bus.ls_req) begin
                    ls_gnt  = 1'b1;
                    state_d = BUSY_LS;
                    if (bus.if_req && starve_q != STARVE_LIM)
                        starve_d = starve_q + 3'd1;
                    we_d    = bus.ls_we;
                    be_d    = bus.ls_be;
                    addr_d  = bus.ls_addr;
                    wdata_d = bus.ls_wdata;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ready) begin
                    state_d     = IDLE;
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = bus.mem_rdata;
                end
            end
            BUSY_LS: begin
                if (bus.mem_ready) begin
                    state_d     = IDLE;
                    ls_rvalid_d = 1'b1;
                    ls_rdata_d  = bus.mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= 3'd0;
            we_q        <= 1'b0;
            be_q        <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'd0;
            ls_rdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.ls_gnt    = ls_gnt;
    assign bus.mem_req   = (state_q != IDLE);
    assign bus.mem_we    = we_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, store, starvation order, mid-transaction reset, idle ready, back-to-back.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge; callers then drive inputs and settle with #1.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'd0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_be     = 4'd0;
        bus.ls_addr   = 32'd0;
        bus.ls_wdata  = 32'd0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst        = 1'b1;
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        cyc(); cyc();
        #1;
        total++; if (bus.if_gnt !== 1'b0) begin bad++; $display("FAIL rst_if_gnt got=%b exp=0", bus.if_gnt); end
        total++; if (bus.ls_gnt !== 1'b0) begin bad++; $display("FAIL rst_ls_gnt got=%b exp=0", bus.ls_gnt); end
        total++; if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'd0) begin bad++; $display("FAIL rst_mem_ctl got=%b exp=0", {bus.mem_req, bus.mem_we, bus.mem_be}); end
        total++; if ({bus.mem_addr, bus.mem_wdata} !== 64'd0) begin bad++; $display("FAIL rst_mem_dat got=%h exp=0", {bus.mem_addr, bus.mem_wdata}); end
        total++; if ({bus.if_rvalid, bus.ls_rvalid, bus.if_rdata, bus.ls_rdata} !== 66'd0) begin bad++; $display("FAIL rst_resp got=%h exp=0", {bus.if_rvalid, bus.ls_rvalid, bus.if_rdata, bus.ls_rdata}); end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        cyc();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        #1;
        total++; if (bus.if_gnt !== 1'b1) begin bad++; $display("FAIL fetch_gnt got=%b exp=1", bus.if_gnt); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL fetch_c0_mem_req got=%b exp=0", bus.mem_req); end
        for (int c = 1; c <= 3; c++) begin
            cyc();
            bus.if_req  = 1'b0;
            bus.if_addr = 32'h0;
            if (c == 3) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hDEADBEEF;
            end
            #1;
            total++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100})
                begin bad++; $display("FAIL fetch_busy c%0d got req=%b we=%b be=%h addr=%h exp 1/0/f/100", c, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr); end
            total++; if (bus.if_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_early_rvalid c%0d got=%b exp=0", c, bus.if_rvalid); end
        end
        cyc();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        total++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL fetch_rvalid got=%b/%h exp=1/deadbeef", bus.if_rvalid, bus.if_rdata); end
        total++; if ({bus.mem_req, bus.ls_rvalid} !== 2'b00) begin bad++; $display("FAIL fetch_done got=%b exp=00", {bus.mem_req, bus.ls_rvalid}); end
        cyc();
        #1;
        total++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL fetch_pulse got=%b/%h exp=0/deadbeef", bus.if_rvalid, bus.if_rdata); end
    endtask

    task automatic test_store();
        cyc();
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_be    = 4'b0011;
        bus.ls_addr  = 32'h200;
        bus.ls_wdata = 32'h1234;
        #1;
        total++; if ({bus.ls_gnt, bus.if_gnt} !== 2'b10) begin bad++; $display("FAIL store_gnt got=%b exp=10", {bus.ls_gnt, bus.if_gnt}); end
        cyc();
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_be     = 4'd0;
        bus.ls_addr   = 32'd0;
        bus.ls_wdata  = 32'd0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555AAAA;
        #1;
        total++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h200, 32'h1234})
            begin bad++; $display("FAIL store_mem got req=%b we=%b be=%b addr=%h wd=%h", bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); end
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        total++; if ({bus.ls_rvalid, bus.if_rvalid, bus.mem_req} !== 3'b100) begin bad++; $display("FAIL store_done got=%b exp=100", {bus.ls_rvalid, bus.if_rvalid, bus.mem_req}); end
        total++; if (bus.if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store_if_rdata_hold got=%h exp=deadbeef", bus.if_rdata); end
        cyc();
        #1;
        total++; if (bus.ls_rvalid !== 1'b0) begin bad++; $display("FAIL store_pulse got=%b exp=0", bus.ls_rvalid); end
    endtask

    task automatic test_starvation();
        // 1 = IF grant expected in that arbitration slot
        logic [5:0] exp_if;
        exp_if = 6'b010000;
        cyc();
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h300;
        bus.ls_req    = 1'b1;
        bus.ls_we     = 1'b0;
        bus.ls_be     = 4'hF;
        bus.ls_addr   = 32'h400;
        bus.mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            total++; if ({bus.if_gnt, bus.ls_gnt} !== {exp_if[i], ~exp_if[i]})
                begin bad++; $display("FAIL starve_order slot%0d got if=%b ls=%b exp if=%b", i, bus.if_gnt, bus.ls_gnt, exp_if[i]); end
            cyc();
            #1;
            total++; if ({bus.if_gnt, bus.ls_gnt, bus.mem_req} !== 3'b001) begin bad++; $display("FAIL starve_busy slot%0d got=%b exp=001", i, {bus.if_gnt, bus.ls_gnt, bus.mem_req}); end
            total++; if (bus.mem_addr !== (exp_if[i] ? 32'h300 : 32'h400)) begin bad++; $display("FAIL starve_addr slot%0d got=%h", i, bus.mem_addr); end
            if (exp_if[i]) begin
                total++; if (dut.starve_q !== 3'd0) begin bad++; $display("FAIL starve_clear got=%0d exp=0", dut.starve_q); end
            end
            cyc();
            if (i == 5) begin
                bus.if_req    = 1'b0;
                bus.ls_req    = 1'b0;
                bus.mem_ready = 1'b0;
            end
            #1;
            total++; if ({bus.if_rvalid, bus.ls_rvalid} !== {exp_if[i], ~exp_if[i]})
                begin bad++; $display("FAIL starve_rvalid slot%0d got if=%b ls=%b", i, bus.if_rvalid, bus.ls_rvalid); end
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 32'h500;
        bus.mem_rdata = 32'hCAFEF00D;
        #1;
        total++; if (bus.ls_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%b exp=1", bus.ls_gnt); end
        cyc();
        bus.ls_req = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        total++; if ({bus.mem_req, bus.ls_rvalid} !== 2'b00) begin bad++; $display("FAIL rmid_c3 got=%b exp=00", {bus.mem_req, bus.ls_rvalid}); end
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        total++; if ({bus.ls_rvalid, bus.if_rvalid, bus.mem_req} !== 3'b000) begin bad++; $display("FAIL rmid_no_rvalid got=%b exp=000", {bus.ls_rvalid, bus.if_rvalid, bus.mem_req}); end
        total++; if ({bus.ls_rdata, bus.if_rdata} !== 64'd0) begin bad++; $display("FAIL rmid_rdata got=%h exp=0", {bus.ls_rdata, bus.if_rdata}); end
        cyc();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h600;
        #1;
        total++; if (bus.if_gnt !== 1'b1) begin bad++; $display("FAIL rmid_idle_gnt got=%b exp=1", bus.if_gnt); end
        cyc();
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b1;
        cyc();
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_idle_ready();
        cyc();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h77777777;
        cyc();
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        total++; if ({bus.if_rvalid, bus.ls_rvalid, bus.mem_req} !== 3'b000) begin bad++; $display("FAIL idle_ready got=%b exp=000", {bus.if_rvalid, bus.ls_rvalid, bus.mem_req}); end
        total++; if (bus.if_rdata === 32'h77777777) begin bad++; $display("FAIL idle_rdata got=%h exp=not 77777777", bus.if_rdata); end
    endtask

    task automatic test_back_to_back();
        cyc();
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h700;
        bus.mem_rdata = 32'h11112222;
        #1;
        total++; if (bus.if_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt0 got=%b exp=1", bus.if_gnt); end
        cyc();
        bus.mem_ready = 1'b1;
        #1;
        total++; if ({bus.if_gnt, bus.ls_gnt} !== 2'b00) begin bad++; $display("FAIL b2b_busy_gnt got=%b exp=00", {bus.if_gnt, bus.ls_gnt}); end
        cyc();
        bus.mem_ready = 1'b0;
        bus.if_addr   = 32'h704;
        #1;
        total++; if ({bus.if_rvalid, bus.if_gnt, bus.if_rdata} !== {2'b11, 32'h11112222}) begin bad++; $display("FAIL b2b_regnt got rv=%b gnt=%b rd=%h", bus.if_rvalid, bus.if_gnt, bus.if_rdata); end
        cyc();
        bus.if_req = 1'b0;
        #1;
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h704}) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/704", bus.mem_req, bus.mem_addr); end
        bus.mem_ready = 1'b1;
        cyc();
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_starvation();
        test_reset_mid();
        test_idle_ready();
        test_back_to_back();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive load/store grants while a fetch request waits.
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch address
- if_gnt  out  1  fetch accepted
- if_rvalid  out  1  fetch data valid
- if_rdata  out  32  fetch data
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store
- ls_be  in  4  byte enables
- ls_addr  in  32  load/store address
- ls_wdata  in  32  store data
- ls_gnt  out  1  load/store accepted
- ls_rvalid  out  1  load data valid / store done
- ls_rdata  out  32  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_be  out  4  memory byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ready  in  1  memory done; mem_rdata valid
- mem_rdata  in  32  memory read data
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, BUSY_IF and BUSY_LS.
REQ-005 Requesters SHALL hold req and all request fields stable until gnt; gnt SHALL be combinational and asserted only in IDLE.
REQ-006 In IDLE with only one req high, that requester SHALL be granted.
REQ-007 In IDLE with both reqs high, LS SHALL be granted unless starve_cnt == STARVE_MAX, in which case IF SHALL be granted.
REQ-008 At most one gnt SHALL be high per cycle.
REQ-009 On grant, addr/we/be/wdata SHALL be registered. For IF, we=0 and be=4'hF. The state SHALL move to BUSY_IF or BUSY_LS on the next edge.
REQ-010 mem_req SHALL be 1 in BUSY states only. mem_* fields SHALL come from the capture registers and stay stable until mem_ready.
REQ-011 Transaction completion:
- On mem_ready in BUSY_x, the state SHALL return to IDLE next cycle.
- x_rvalid SHALL pulse exactly one cycle, on the cycle after mem_ready.
- x_rdata SHALL be registered from mem_rdata on that edge and hold until the next completion for x.
REQ-012 ls_rvalid SHALL pulse for stores as well. ls_rdata is don't-care for stores.
REQ-013 mem_ready SHALL be ignored in IDLE.
REQ-014 Starvation counter, starve_cnt, 3 bits:
- increments on an LS grant while if_req=1, saturating at STARVE_MAX;
- clears to 0 on any IF grant;
- holds otherwise.
REQ-015 Minimum latency: req in IDLE at cycle 0 → gnt cycle 0, mem_req cycle 1. With mem_ready at cycle 1, rvalid at cycle 2, and the next grant is possible at cycle 2.
REQ-016 No grant SHALL occur in BUSY states, even when mem_ready=1 in that cycle.

Reset
REQ-017 On rst=1 at an edge:
- state=IDLE, starve_cnt=0;
- mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0;
- if_rvalid=0, ls_rvalid=0, if_rdata=0, ls_rdata=0.
REQ-018 While rst=1, if_gnt and ls_gnt SHALL be 0.
REQ-019 Reset mid-transaction SHALL abandon it: no rvalid pulse, and a subsequent mem_ready is ignored.

Verification
REQ-020 Fetch only: if_req=1, if_addr=0x100, mem_ready at cycle 3 with mem_rdata=0xDEADBEEF → if_gnt cycle 0, mem_addr=0x100 and mem_we=0 for cycles 1-3, if_rvalid=1 with if_rdata=0xDEADBEEF at cycle 4.
REQ-021 Store: ls_req=1, ls_we=1, ls_be=4'b0011, ls_addr=0x200, ls_wdata=0x1234, mem_ready at cycle 1 → mem_we=1, mem_be=4'b0011 cycle 1; ls_rvalid cycle 2; if_rvalid stays 0.
REQ-022 Simultaneous requests, STARVE_MAX=4, both reqs held high, mem_ready every BUSY cycle → grant order LS,LS,LS,LS,IF,LS,…; starve_cnt=0 after the IF grant.
REQ-023 Reset mid-transaction: rst at cycle 2 of BUSY_LS, then mem_ready=1 at cycle 3 → no ls_rvalid; mem_req=0 from cycle 3; state IDLE.
REQ-024 mem_ready=1 while IDLE with no request → no rvalid, no state change.
REQ-025 Back-to-back: if_req held while mem_ready arrives in BUSY_IF → no gnt that cycle; next if_gnt on the rvalid cycle.
